// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer
// Initialization / operation command sequencer for an 8259A-compatible PIC.
// Walks ICW1 -> ICW2 -> (ICW3) -> (ICW4) and then decodes OCW1/OCW2/OCW3.
// Every programmed field is held in a register for the downstream blocks.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   write_strobe          : one-cycle pulse for a completed CPU write
//   address               : latched A0 of that write
//   internal_data_bus     : latched write data
//   init_done             : 1 once the ICW sequence has finished
//   icw1_strobe           : one-cycle pulse after an accepted ICW1
//   level_triggered, single_mode, address_interval_4 : ICW1 fields
//   vector_base           : ICW2 D7..D3
//   cascade_config        : ICW3 byte
//   mode_8086, auto_eoi, buffered_master, buffered_mode,
//   special_fully_nested  : ICW4 fields
//   interrupt_mask        : OCW1 mask
//   ocw2_strobe, ocw2_command, ocw2_level : OCW2 pulse and its fields
//   auto_rotate           : rotate-on-AEOI flag
//   special_mask_mode     : OCW3 SMM state
//   read_isr_select       : 0 = read IRR, 1 = read ISR
//   poll_strobe           : one-cycle pulse on an OCW3 poll command
module pic_command_sequencer #(
  parameter logic [7:0] RESET_MASK = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic       address,
  input  logic [7:0] internal_data_bus,
  output logic       init_done,
  output logic       icw1_strobe,
  output logic       level_triggered,
  output logic       single_mode,
  output logic       address_interval_4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       mode_8086,
  output logic       auto_eoi,
  output logic       buffered_master,
  output logic       buffered_mode,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       ocw2_strobe,
  output logic [2:0] ocw2_command,
  output logic [2:0] ocw2_level,
  output logic       auto_rotate,
  output logic       special_mask_mode,
  output logic       read_isr_select,
  output logic       poll_strobe
);

  localparam logic [2:0] UNINIT    = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  logic [2:0] state_reg;
  logic       ic4_reg;
  logic       is_icw1;

  // ICW1 is recognised in every state, so it is decoded ahead of the FSM.
  assign is_icw1 = ~address & internal_data_bus[4];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg            <= UNINIT;
      ic4_reg              <= 1'b0;
      init_done            <= 1'b0;
      icw1_strobe          <= 1'b0;
      level_triggered      <= 1'b0;
      single_mode          <= 1'b0;
      address_interval_4   <= 1'b0;
      vector_base          <= 5'd0;
      cascade_config       <= 8'h00;
      mode_8086            <= 1'b0;
      auto_eoi             <= 1'b0;
      buffered_master      <= 1'b0;
      buffered_mode        <= 1'b0;
      special_fully_nested <= 1'b0;
      interrupt_mask       <= RESET_MASK;
      ocw2_strobe          <= 1'b0;
      ocw2_command         <= 3'd0;
      ocw2_level           <= 3'd0;
      auto_rotate          <= 1'b0;
      special_mask_mode    <= 1'b0;
      read_isr_select      <= 1'b0;
      poll_strobe          <= 1'b0;
    end else begin
      // Strobes last exactly one cycle after the accepting edge.
      icw1_strobe <= 1'b0;
      ocw2_strobe <= 1'b0;
      poll_strobe <= 1'b0;

      if (write_strobe) begin
        if (is_icw1) begin
          level_triggered    <= internal_data_bus[3];
          address_interval_4 <= internal_data_bus[2];
          single_mode        <= internal_data_bus[1];
          ic4_reg            <= internal_data_bus[0];
          interrupt_mask     <= 8'h00;
          special_mask_mode  <= 1'b0;
          read_isr_select    <= 1'b0;
          auto_rotate        <= 1'b0;
          if (!internal_data_bus[0]) begin
            mode_8086            <= 1'b0;
            auto_eoi             <= 1'b0;
            buffered_master      <= 1'b0;
            buffered_mode        <= 1'b0;
            special_fully_nested <= 1'b0;
          end
          icw1_strobe <= 1'b1;
          init_done   <= 1'b0;
          state_reg   <= WAIT_ICW2;
        end else begin
          case (state_reg)
            WAIT_ICW2: begin
              if (address) begin
                vector_base <= internal_data_bus[7:3];
                // single_mode/ic4_reg already hold this sequence's ICW1 values.
                if (!single_mode) begin
                  state_reg <= WAIT_ICW3;
                end else if (ic4_reg) begin
                  state_reg <= WAIT_ICW4;
                end else begin
                  state_reg <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            WAIT_ICW3: begin
              if (address) begin
                cascade_config <= internal_data_bus;
                if (ic4_reg) begin
                  state_reg <= WAIT_ICW4;
                end else begin
                  state_reg <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            WAIT_ICW4: begin
              if (address) begin
                mode_8086            <= internal_data_bus[0];
                auto_eoi             <= internal_data_bus[1];
                buffered_master      <= internal_data_bus[2];
                buffered_mode        <= internal_data_bus[3];
                special_fully_nested <= internal_data_bus[4];
                state_reg            <= READY;
                init_done            <= 1'b1;
              end
            end
            READY: begin
              if (address) begin
                interrupt_mask <= internal_data_bus;
              end else if (!internal_data_bus[3]) begin
                ocw2_strobe  <= 1'b1;
                ocw2_command <= internal_data_bus[7:5];
                ocw2_level   <= internal_data_bus[2:0];
                if (internal_data_bus[7:5] == 3'b100) begin
                  auto_rotate <= 1'b1;
                end else if (internal_data_bus[7:5] == 3'b000) begin
                  auto_rotate <= 1'b0;
                end
              end else begin
                if (internal_data_bus[6]) begin
                  special_mask_mode <= internal_data_bus[5];
                end
                if (internal_data_bus[1]) begin
                  read_isr_select <= internal_data_bus[0];
                end
                if (internal_data_bus[2]) begin
                  poll_strobe <= 1'b1;
                end
              end
            end
            default: begin
              // UNINIT: only ICW1 has any effect.
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed testbench for pic_command_sequencer.
module tb_pic_command_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic       address = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       init_done, icw1_strobe, level_triggered, single_mode, address_interval_4;
  logic [4:0] vector_base;
  logic [7:0] cascade_config;
  logic       mode_8086, auto_eoi, buffered_master, buffered_mode, special_fully_nested;
  logic [7:0] interrupt_mask;
  logic       ocw2_strobe;
  logic [2:0] ocw2_command, ocw2_level;
  logic       auto_rotate, special_mask_mode, read_isr_select, poll_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pic_command_sequencer #(.RESET_MASK(8'hFF)) dut (
    .clock(clock), .reset(reset), .write_strobe(write_strobe), .address(address),
    .internal_data_bus(internal_data_bus), .init_done(init_done), .icw1_strobe(icw1_strobe),
    .level_triggered(level_triggered), .single_mode(single_mode),
    .address_interval_4(address_interval_4), .vector_base(vector_base),
    .cascade_config(cascade_config), .mode_8086(mode_8086), .auto_eoi(auto_eoi),
    .buffered_master(buffered_master), .buffered_mode(buffered_mode),
    .special_fully_nested(special_fully_nested), .interrupt_mask(interrupt_mask),
    .ocw2_strobe(ocw2_strobe), .ocw2_command(ocw2_command), .ocw2_level(ocw2_level),
    .auto_rotate(auto_rotate), .special_mask_mode(special_mask_mode),
    .read_isr_select(read_isr_select), .poll_strobe(poll_strobe)
  );

  // One write: strobe across one rising edge; returns at the next falling
  // edge, where the written state and any strobe are visible.
  task automatic wr(input logic a0, input logic [7:0] d);
    @(negedge clock);
    write_strobe = 1'b1;
    address = a0;
    internal_data_bus = d;
    @(negedge clock);
    write_strobe = 1'b0;
    $display("write a0=%0d data=%02h -> init_done=%0d mask=%02h", a0, d, init_done, interrupt_mask);
  endtask

  task automatic idle();
    @(negedge clock);
  endtask

  // Packs all single-bit/multi-bit outputs for compact reset comparison.
  function automatic logic [47:0] pack_outs();
    return {init_done, icw1_strobe, level_triggered, single_mode, address_interval_4,
            vector_base, cascade_config, mode_8086, auto_eoi, buffered_master,
            buffered_mode, special_fully_nested, interrupt_mask, ocw2_strobe,
            ocw2_command, ocw2_level, auto_rotate, special_mask_mode,
            read_isr_select, poll_strobe};
  endfunction

  localparam logic [47:0] RESET_PACK = {5'b0, 5'd0, 8'h00, 5'b0, 8'hFF, 1'b0, 3'd0, 3'd0, 4'b0};

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (pack_outs() !== RESET_PACK) begin
      errors++;
      $display("FAIL reset_values: got %012h expected %012h", pack_outs(), RESET_PACK);
    end
    wr(1'b1, 8'h55);
    checks++;
    if (interrupt_mask !== 8'hFF || init_done !== 1'b0) begin
      errors++;
      $display("FAIL uninit_ocw1_ignored: mask=%02h init_done=%0d expected FF/0", interrupt_mask, init_done);
    end
  endtask

  task automatic test_single_ic4();
    wr(1'b0, 8'h13);
    checks++;
    if (icw1_strobe !== 1'b1 || single_mode !== 1'b1 || interrupt_mask !== 8'h00) begin
      errors++;
      $display("FAIL icw1_accept: strobe=%0d sngl=%0d mask=%02h expected 1/1/00", icw1_strobe, single_mode, interrupt_mask);
    end
    idle();
    checks++;
    if (icw1_strobe !== 1'b0) begin
      errors++;
      $display("FAIL icw1_strobe_width: got %0d expected 0", icw1_strobe);
    end
    // A0=0 with D4=0 is ignored while waiting for ICW2.
    wr(1'b0, 8'h08);
    wr(1'b1, 8'h40);
    checks++;
    if (vector_base !== 5'h08 || init_done !== 1'b0 || ocw2_strobe !== 1'b0) begin
      errors++;
      $display("FAIL icw2: vb=%02h init_done=%0d expected 08/0", vector_base, init_done);
    end
    wr(1'b1, 8'h03);
    checks++;
    if (init_done !== 1'b1 || mode_8086 !== 1'b1 || auto_eoi !== 1'b1 || buffered_mode !== 1'b0 || cascade_config !== 8'h00) begin
      errors++;
      $display("FAIL icw4: init_done=%0d upm=%0d aeoi=%0d buf=%0d cas=%02h expected 1/1/1/0/00",
               init_done, mode_8086, auto_eoi, buffered_mode, cascade_config);
    end
  endtask

  task automatic test_cascade_no_ic4();
    wr(1'b0, 8'h10);
    checks++;
    if (mode_8086 !== 1'b0 || auto_eoi !== 1'b0 || init_done !== 1'b0 || single_mode !== 1'b0) begin
      errors++;
      $display("FAIL icw1_clear_icw4: upm=%0d aeoi=%0d init_done=%0d sngl=%0d expected 0/0/0/0",
               mode_8086, auto_eoi, init_done, single_mode);
    end
    wr(1'b1, 8'h20);
    checks++;
    if (vector_base !== 5'h04 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL cascade_icw2: vb=%02h init_done=%0d expected 04/0", vector_base, init_done);
    end
    wr(1'b1, 8'h04);
    checks++;
    if (cascade_config !== 8'h04 || init_done !== 1'b1 || special_fully_nested !== 1'b0) begin
      errors++;
      $display("FAIL icw3: cas=%02h init_done=%0d sfnm=%0d expected 04/1/0", cascade_config, init_done, special_fully_nested);
    end
  endtask

  task automatic test_ocw();
    wr(1'b1, 8'hA5);
    checks++;
    if (interrupt_mask !== 8'hA5) begin
      errors++;
      $display("FAIL ocw1: mask=%02h expected A5", interrupt_mask);
    end
    wr(1'b0, 8'h63);
    checks++;
    if (ocw2_strobe !== 1'b1 || ocw2_command !== 3'b011 || ocw2_level !== 3'd3 || auto_rotate !== 1'b0) begin
      errors++;
      $display("FAIL ocw2_seoi: strobe=%0d cmd=%0d lvl=%0d rot=%0d expected 1/3/3/0", ocw2_strobe, ocw2_command, ocw2_level, auto_rotate);
    end
    idle();
    checks++;
    if (ocw2_strobe !== 1'b0 || ocw2_command !== 3'b011) begin
      errors++;
      $display("FAIL ocw2_hold: strobe=%0d cmd=%0d expected 0/3", ocw2_strobe, ocw2_command);
    end
    wr(1'b0, 8'h80);
    checks++;
    if (auto_rotate !== 1'b1) begin
      errors++;
      $display("FAIL ocw2_rot_set: got %0d expected 1", auto_rotate);
    end
    wr(1'b0, 8'h20);
    checks++;
    if (auto_rotate !== 1'b1 || ocw2_command !== 3'b001) begin
      errors++;
      $display("FAIL ocw2_rot_keep: rot=%0d cmd=%0d expected 1/1", auto_rotate, ocw2_command);
    end
    wr(1'b0, 8'h00);
    checks++;
    if (auto_rotate !== 1'b0) begin
      errors++;
      $display("FAIL ocw2_rot_clear: got %0d expected 0", auto_rotate);
    end
    wr(1'b0, 8'h6B);
    checks++;
    if (special_mask_mode !== 1'b1 || read_isr_select !== 1'b1 || poll_strobe !== 1'b0 || ocw2_strobe !== 1'b0) begin
      errors++;
      $display("FAIL ocw3: smm=%0d ris=%0d poll=%0d o2=%0d expected 1/1/0/0", special_mask_mode, read_isr_select, poll_strobe, ocw2_strobe);
    end
    // Poll only; ESMM=0 and RR=0 leave SMM and RIS untouched.
    wr(1'b0, 8'h0C);
    checks++;
    if (poll_strobe !== 1'b1 || special_mask_mode !== 1'b1 || read_isr_select !== 1'b1) begin
      errors++;
      $display("FAIL ocw3_poll: poll=%0d smm=%0d ris=%0d expected 1/1/1", poll_strobe, special_mask_mode, read_isr_select);
    end
    idle();
    checks++;
    if (poll_strobe !== 1'b0) begin
      errors++;
      $display("FAIL poll_width: got %0d expected 0", poll_strobe);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    write_strobe = 1'b1; address = 1'b1; internal_data_bus = 8'h3C;
    @(negedge clock);
    address = 1'b0; internal_data_bus = 8'hE5;
    @(negedge clock);
    write_strobe = 1'b0;
    $display("back-to-back OCW1=3C, OCW2=E5 -> mask=%02h cmd=%0d", interrupt_mask, ocw2_command);
    checks++;
    if (interrupt_mask !== 8'h3C || ocw2_strobe !== 1'b1 || ocw2_command !== 3'b111 || ocw2_level !== 3'd5) begin
      errors++;
      $display("FAIL back_to_back: mask=%02h strobe=%0d cmd=%0d lvl=%0d expected 3C/1/7/5",
               interrupt_mask, ocw2_strobe, ocw2_command, ocw2_level);
    end
  endtask

  task automatic test_restart();
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h20);
    wr(1'b0, 8'h13);
    checks++;
    if (icw1_strobe !== 1'b1 || interrupt_mask !== 8'h00 || init_done !== 1'b0 ||
        special_mask_mode !== 1'b0 || read_isr_select !== 1'b0 || single_mode !== 1'b1) begin
      errors++;
      $display("FAIL restart_icw1: strobe=%0d mask=%02h init=%0d smm=%0d ris=%0d sngl=%0d expected 1/00/0/0/0/1",
               icw1_strobe, interrupt_mask, init_done, special_mask_mode, read_isr_select, single_mode);
    end
    // Back in WAIT_ICW2: next A0=1 is ICW2, then ICW4 (single, IC4).
    wr(1'b1, 8'h48);
    checks++;
    if (vector_base !== 5'h09 || init_done !== 1'b0 || cascade_config !== 8'h04) begin
      errors++;
      $display("FAIL restart_icw2: vb=%02h init=%0d cas=%02h expected 09/0/04", vector_base, init_done, cascade_config);
    end
    wr(1'b1, 8'h1C);
    checks++;
    if (init_done !== 1'b1 || special_fully_nested !== 1'b1 || buffered_mode !== 1'b1 ||
        buffered_master !== 1'b1 || mode_8086 !== 1'b0 || interrupt_mask !== 8'h00) begin
      errors++;
      $display("FAIL restart_icw4: init=%0d sfnm=%0d buf=%0d bm=%0d upm=%0d mask=%02h expected 1/1/1/1/0/00",
               init_done, special_fully_nested, buffered_mode, buffered_master, mode_8086, interrupt_mask);
    end
  endtask

  task automatic test_reset_with_write();
    @(negedge clock);
    reset = 1'b1; write_strobe = 1'b1; address = 1'b1; internal_data_bus = 8'h55;
    @(negedge clock);
    reset = 1'b0; write_strobe = 1'b0;
    $display("reset with OCW1=55 -> init_done=%0d mask=%02h", init_done, interrupt_mask);
    checks++;
    if (pack_outs() !== RESET_PACK) begin
      errors++;
      $display("FAIL reset_dominates: got %012h expected %012h", pack_outs(), RESET_PACK);
    end
    wr(1'b1, 8'h00);
    checks++;
    if (interrupt_mask !== 8'hFF) begin
      errors++;
      $display("FAIL post_reset_uninit: mask=%02h expected FF", interrupt_mask);
    end
  endtask

  initial begin
    test_reset();
    test_single_ic4();
    test_cascade_no_ic4();
    test_ocw();
    test_back_to_back();
    test_restart();
    test_reset_with_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_command_sequencer.md
Name: pic_command_sequencer

Overview:
- Command/initialization sequencer for the 8259A-compatible PIC.
- Consumes a one-cycle write strobe, the latched A0 and the latched 8-bit internal data bus from the bus control logic.
- Steps through the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence, then decodes OCW1/OCW2/OCW3 in operational mode.
- Holds every programmed configuration field as a register and drives it to the priority resolver, IRR/ISR and cascade logic.

Parameters:
- RESET_MASK, 8'hFF, OCW1 mask value after reset (all IRs masked until programmed).

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; dominates every other input
- write_strobe  input  1  one-cycle pulse marking a completed CPU write
- address  input  1  latched A0 for the write
- internal_data_bus  input  8  latched write data, stable while write_strobe=1
- init_done  output  1  1 = operational mode (initialization sequence complete)
- icw1_strobe  output  1  one-cycle pulse after an accepted ICW1 (clears IRR edge logic/ISR downstream)
- level_triggered  output  1  ICW1 D3 (LTIM)
- single_mode  output  1  ICW1 D1 (SNGL)
- address_interval_4  output  1  ICW1 D2 (ADI)
- vector_base  output  5  ICW2 D7..D3
- cascade_config  output  8  ICW3 byte (slave mask when master, D2..D0 = ID when slave)
- mode_8086  output  1  ICW4 D0 (uPM)
- auto_eoi  output  1  ICW4 D1
- buffered_master  output  1  ICW4 D2
- buffered_mode  output  1  ICW4 D3
- special_fully_nested  output  1  ICW4 D4
- interrupt_mask  output  8  OCW1 mask
- ocw2_strobe  output  1  one-cycle pulse on an accepted OCW2
- ocw2_command  output  3  OCW2 D7..D5 (R, SL, EOI), valid while ocw2_strobe=1, held otherwise
- ocw2_level  output  3  OCW2 D2..D0, same timing as ocw2_command
- auto_rotate  output  1  rotate-on-AEOI mode flag
- special_mask_mode  output  1  OCW3 SMM state
- read_isr_select  output  1  0 = read IRR, 1 = read ISR
- poll_strobe  output  1  one-cycle pulse on an OCW3 with P=1

Behaviour:
- Reset values:
  - State UNINIT; init_done=0.
  - All strobes 0.
  - All ICW fields 0; cascade_config=8'h00.
  - interrupt_mask=RESET_MASK.
  - ocw2_command/ocw2_level=0.
  - auto_rotate=0, special_mask_mode=0, read_isr_select=0.
- Command is "accepted" on a rising edge where write_strobe=1. Registers and state update on that edge and are visible the following cycle. Strobes are high for exactly that one following cycle.
- ICW1 = address=0 and D4=1. Accepted in every state, including mid-sequence and READY (restarts initialization). Effects:
  - latch LTIM/ADI/SNGL;
  - store IC4=D0 internally;
  - clear interrupt_mask to 8'h00, special_mask_mode, read_isr_select, auto_rotate;
  - if IC4=0, clear all ICW4 fields;
  - pulse icw1_strobe; init_done←0; next state WAIT_ICW2.
- WAIT_ICW2: address=1 write latches vector_base. Next state:
  - WAIT_ICW3 if SNGL=0;
  - else WAIT_ICW4 if IC4=1;
  - else READY.
- WAIT_ICW3: address=1 write latches cascade_config. Next state WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4: address=1 write latches ICW4 D4..D0. Next state READY.
- In WAIT_* states, address=0 writes with D4=0 are ignored; state is unchanged.
- UNINIT: all writes except ICW1 are ignored.
- On entry to READY, init_done=1 in the same cycle the final ICW's fields become visible.
- READY decode:
  - address=1 → OCW1: interrupt_mask←data.
  - address=0, D4=0, D3=0 → OCW2: pulse ocw2_strobe with command/level. Command 3'b100 sets auto_rotate; 3'b000 clears it; other codes leave it unchanged.
  - address=0, D4=0, D3=1 → OCW3:
    - if D6(ESMM)=1, special_mask_mode←D5;
    - if D1(RR)=1, read_isr_select←D0;
    - if D2(P)=1, pulse poll_strobe.
- Back-to-back strobes on consecutive cycles are each processed fully; no write is dropped.
- Reset asserted mid-sequence returns to UNINIT with all reset values next cycle, regardless of write_strobe.

Test Plan:
- Reset, then OCW1 write (A0=1, 8'h55) before any ICW1 → interrupt_mask stays 8'hFF, init_done=0.
- ICW1=8'h13 (single, IC4), ICW2=8'h40, ICW4=8'h03 → ICW3 skipped; vector_base=5'h08, mode_8086=1, auto_eoi=1; init_done=1 the cycle after the ICW4 strobe; icw1_strobe high exactly one cycle.
- ICW1=8'h10 (cascade, no IC4), ICW2=8'h20, ICW3=8'h04 → cascade_config=8'h04, ICW4 fields all 0, READY after ICW3.
- In READY: OCW1=8'hA5 → mask=8'hA5; OCW2=8'h63 → ocw2_strobe one cycle, command=3'b011, level=3; OCW2=8'h80 → auto_rotate=1; OCW3=8'h6B → special_mask_mode=1, read_isr_select=1, poll_strobe=0.
- Mid-sequence restart: ICW1, ICW2, then ICW1=8'h13 again instead of ICW3 → state WAIT_ICW2, mask=8'h00, second icw1_strobe pulse.
- Reset asserted in the same cycle as write_strobe with OCW1 data → all outputs at reset values next cycle, interrupt_mask=RESET_MASK.
